// File: rtl/fuzz_log_pkg.sv
// fuzz_log_pkg: shared constants, header layout, record sizing and reader FSM states for the crash log
package fuzz_log_pkg;
  localparam logic [7:0] LOG_SYNC = 8'hA5;
  localparam int HDR_SYNC_LSB = 24;
  localparam int HDR_SEQ_LSB = 16;
  localparam int HDR_COV_LSB = 8;
  localparam int HDR_COL_BIT = 1;
  localparam int HDR_HANG_BIT = 0;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM} log_state_t;
  function automatic int log_words(int iw, int ow);
    return 1 + iw / 32 + ow / 32;
  endfunction
  function automatic logic [31:0] log_header(logic [7:0] seq, logic [7:0] cov, logic col, logic hang);
    logic [31:0] h;
    h = '0;
    h[HDR_SYNC_LSB +: 8] = LOG_SYNC;
    h[HDR_SEQ_LSB +: 8] = seq;
    h[HDR_COV_LSB +: 8] = cov;
    h[HDR_COL_BIT] = col;
    h[HDR_HANG_BIT] = hang;
    return h;
  endfunction
endpackage

// File: rtl/log_fifo.sv
// log_fifo: single-clock record FIFO (clk, rst, clr flush, push/din, pop/dout, count, full, empty); push while full succeeds when popping in the same cycle
module log_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/crash_log_reader.sv
// crash_log_reader: latches alarm-edge crash records (alarms, coverage, error_input/output) into a FIFO and streams them as 32-bit words (rd_valid/rd_ready/rd_data/rd_last) with log_count, log_full, drop_count status
module crash_log_reader import fuzz_log_pkg::*; #(
  parameter int INPUT_WIDTH = 256,
  parameter int OUTPUT_WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       alarm_hang,
  input  logic                       alarm_collision,
  input  logic [7:0]                 coverage_score,
  input  logic [INPUT_WIDTH-1:0]     error_input,
  input  logic [OUTPUT_WIDTH-1:0]    error_output,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [31:0]                rd_data,
  output logic                       rd_last,
  output logic [$clog2(DEPTH+1)-1:0] log_count,
  output logic                       log_full,
  output logic [7:0]                 drop_count
);
  localparam int W = log_words(INPUT_WIDTH, OUTPUT_WIDTH);
  localparam int DW = INPUT_WIDTH + OUTPUT_WIDTH;
  localparam int RW = 18 + DW;
  localparam int IXW = $clog2(W);
  logic hang_q, col_q, trig, pop, push_ok, fifo_empty;
  logic [7:0] seq;
  logic [RW-1:0] head;
  logic [W*32-1:0] sh;
  logic [IXW-1:0] idx;
  log_state_t state;
  assign trig = ((alarm_hang & ~hang_q) | (alarm_collision & ~col_q)) & ~clr;
  assign pop = (state == LOAD) & ~clr;
  assign push_ok = trig & (~log_full | pop);
  assign rd_data = sh[W*32-1 -: 32];
  log_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .push(trig),
    .pop(pop),
    .din({alarm_collision, alarm_hang, coverage_score, seq, error_input, error_output}),
    .dout(head),
    .count(log_count),
    .full(log_full),
    .empty(fifo_empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hang_q <= 1'b0;
      col_q <= 1'b0;
      seq <= '0;
      drop_count <= '0;
      state <= IDLE;
      idx <= '0;
      sh <= '0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      hang_q <= alarm_hang;
      col_q <= alarm_collision;
      if (clr) begin
        seq <= '0;
        drop_count <= '0;
        state <= IDLE;
        rd_valid <= 1'b0;
        rd_last <= 1'b0;
      end else begin
        if (push_ok) seq <= seq + 1'b1;
        else if (trig && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
        case (state)
          IDLE: if (!fifo_empty) state <= LOAD;
          LOAD: begin
            sh <= {log_header(head[RW-11 -: 8], head[RW-3 -: 8], head[RW-1], head[RW-2]), head[DW-1:0]};
            idx <= '0;
            rd_valid <= 1'b1;
            rd_last <= 1'b0;
            state <= STREAM;
          end
          STREAM: if (rd_ready) begin
            sh <= sh << 32;
            idx <= idx + 1'b1;
            rd_last <= idx == IXW'(W-2);
            if (rd_last) begin
              rd_valid <= 1'b0;
              rd_last <= 1'b0;
              state <= fifo_empty ? IDLE : LOAD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_crash_log_reader.sv
// tb_crash_log_reader: randomized scenario bench for crash_log_reader against a queue-based record model
module tb_crash_log_reader;
  localparam int IW = 256;
  localparam int OW = 128;
  localparam int DEPTH = 8;
  localparam int WPR = 1 + IW / 32 + OW / 32;
  logic clk = 1'b0;
  logic rst, clr, alarm_hang, alarm_collision, rd_ready;
  logic [7:0] coverage_score;
  logic [IW-1:0] error_input;
  logic [OW-1:0] error_output;
  logic rd_valid, rd_last, log_full;
  logic [31:0] rd_data;
  logic [3:0] log_count;
  logic [7:0] drop_count;
  int errs = 0;
  int checks = 0;
  crash_log_reader #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .alarm_hang(alarm_hang), .alarm_collision(alarm_collision),
    .coverage_score(coverage_score), .error_input(error_input), .error_output(error_output),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .log_count(log_count), .log_full(log_full), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] fl;
    logic [7:0] cov;
    logic [7:0] seq;
    logic [IW-1:0] ei;
    logic [OW-1:0] eo;
  } rec_t;
  typedef logic [31:0] wq_t[$];
  rec_t mq[$];
  wq_t mw;
  rec_t r;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  logic hq, cq, mtrig;
  logic [7:0] mseq, mdrop;
  int ph, n;
  function automatic wq_t words_of(rec_t x);
    wq_t q;
    q.push_back({8'hA5, x.seq, x.cov, 6'b0, x.fl});
    for (int i = 1; i <= IW / 32; i++) q.push_back(32'(x.ei >> (IW - 32 * i)));
    for (int i = 1; i <= OW / 32; i++) q.push_back(32'(x.eo >> (OW - 32 * i)));
    return q;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      hq = 1'b0; cq = 1'b0; mseq = '0; mdrop = '0; ph = 0;
      mq.delete(); mw.delete();
    end else begin
      if (rd_valid && rd_ready) begin
        got_q.push_back({rd_last, rd_data});
        exp_q.push_back(mw.size() != 0 ? {mw.size() == 1, mw[0]} : 33'bx);
      end
      mtrig = (alarm_hang && !hq) || (alarm_collision && !cq);
      r = '{fl: {alarm_collision, alarm_hang}, cov: coverage_score, seq: mseq, ei: error_input, eo: error_output};
      hq = alarm_hang;
      cq = alarm_collision;
      if (clr) begin
        mq.delete(); mw.delete(); mseq = '0; mdrop = '0; ph = 0;
      end else begin
        n = mq.size();
        if (ph == 1) begin
          mw = words_of(mq.pop_front());
          ph = 2;
        end else if (ph == 2) begin
          if (rd_ready) void'(mw.pop_front());
          if (mw.size() == 0) ph = n != 0 ? 1 : 0;
        end else if (n != 0) ph = 1;
        if (mtrig) begin
          if (mq.size() < DEPTH) begin
            mq.push_back(r);
            mseq++;
          end else if (mdrop != 8'hFF) mdrop++;
        end
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_data();
    coverage_score = 8'($urandom);
    for (int i = 0; i < IW / 32; i++) error_input[i*32 +: 32] = $urandom;
    for (int i = 0; i < OW / 32; i++) error_output[i*32 +: 32] = $urandom;
  endtask
  task automatic flush();
    alarm_hang = 1'b0; alarm_collision = 1'b0; rd_ready = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    got_q.delete(); exp_q.delete();
  endtask
  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; alarm_hang = 1'b0; alarm_collision = 1'b0; rd_ready = 1'b0;
    coverage_score = '0; error_input = '0; error_output = '0;
    repeat (2) step();
    checks++;
    if ({rd_valid, rd_last, rd_data} !== 34'd0) begin errs++; $display("FAIL reset_stream: got valid=%b last=%b data=%h want 0", rd_valid, rd_last, rd_data); end
    checks++;
    if ({log_full, log_count, drop_count} !== 13'd0) begin errs++; $display("FAIL reset_status: got full=%b count=%0d drop=%0d want 0", log_full, log_count, drop_count); end
    rst = 1'b0;
    step();
  endtask
  task automatic test_single_hang();
    got_q.delete(); exp_q.delete();
    coverage_score = 8'h3C;
    error_input = 256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;
    error_output = 128'hDEAD0123456789ABCDEF00112233BEEF;
    rd_ready = 1'b1;
    alarm_hang = 1'b1;
    step();
    checks++;
    if (log_count !== 4'd1 || rd_valid !== 1'b0) begin errs++; $display("FAIL hang_edge_n: got count=%0d valid=%b want 1/0", log_count, rd_valid); end
    step();
    checks++;
    if (rd_valid !== 1'b0) begin errs++; $display("FAIL hang_edge_n1: got valid=%b want 0", rd_valid); end
    step();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hA5003C01 || log_count !== 4'd0) begin errs++; $display("FAIL hang_header: got valid=%b data=%h count=%0d want 1/a5003c01/0", rd_valid, rd_data, log_count); end
    for (int i = 0; i < 40 && got_q.size() < WPR; i++) step();
    checks++;
    if (got_q.size() != WPR) begin errs++; $display("FAIL hang_words: got %0d words want %0d", got_q.size(), WPR); end
    for (int i = 0; i < got_q.size() && i < WPR; i++) begin
      checks++;
      if (got_q[i] !== {i == WPR - 1, i == 0 ? 32'hA5003C01 : i <= IW / 32 ? 32'(error_input >> (IW - 32 * i)) : 32'(error_output >> (OW - 32 * (i - IW / 32)))}) begin
        errs++; $display("FAIL hang_word%0d: got %h want slice of pattern", i, got_q[i]);
      end
    end
    checks++;
    if (log_count !== 4'd0) begin errs++; $display("FAIL hang_count_end: got %0d want 0", log_count); end
    alarm_hang = 1'b0;
    step();
  endtask
  task automatic test_simultaneous();
    got_q.delete(); exp_q.delete();
    set_data();
    rd_ready = 1'b1;
    alarm_hang = 1'b1; alarm_collision = 1'b1;
    repeat (50) step();
    checks++;
    if (got_q.size() != WPR) begin errs++; $display("FAIL simul_count: got %0d words want %0d", got_q.size(), WPR); end
    checks++;
    if (got_q.size() == 0 || got_q[0][1:0] !== 2'b11 || got_q[0][31:24] !== 8'hA5) begin errs++; $display("FAIL simul_flags: got header %h want a5....03", got_q.size() ? got_q[0] : 33'h0); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL simul_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    alarm_hang = 1'b0; alarm_collision = 1'b0;
    step();
  endtask
  task automatic test_overflow();
    flush();
    set_data();
    alarm_hang = 1'b1;
    step();
    alarm_hang = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 10; i++) begin
      set_data();
      alarm_hang = i % 2 == 0;
      alarm_collision = i % 2 == 1;
      step();
      if (i == 6) begin
        checks++;
        if (log_full !== 1'b0 || log_count !== 4'd7) begin errs++; $display("FAIL ovf_seven: got full=%b count=%0d want 0/7", log_full, log_count); end
      end
      if (i == 7) begin
        checks++;
        if (log_full !== 1'b1 || log_count !== 4'd8) begin errs++; $display("FAIL ovf_full: got full=%b count=%0d want 1/8", log_full, log_count); end
      end
    end
    alarm_hang = 1'b0; alarm_collision = 1'b0;
    step();
    checks++;
    if (drop_count !== 8'd2 || drop_count !== mdrop) begin errs++; $display("FAIL ovf_drop: got %0d want 2 (model %0d)", drop_count, mdrop); end
    rd_ready = 1'b1;
    for (int i = 0; i < 400 && got_q.size() < 9 * WPR; i++) step();
    checks++;
    if (got_q.size() != 9 * WPR) begin errs++; $display("FAIL ovf_words: got %0d want %0d", got_q.size(), 9 * WPR); end
    for (int k = 0; k < 9 && k * WPR < got_q.size(); k++) begin
      checks++;
      if (got_q[k*WPR][23:16] !== 8'(k)) begin errs++; $display("FAIL ovf_seq%0d: got %0d want %0d", k, got_q[k*WPR][23:16], k); end
    end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL ovf_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask
  task automatic test_full_pop();
    flush();
    set_data();
    alarm_hang = 1'b1;
    step();
    alarm_hang = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 8; i++) begin
      set_data();
      alarm_hang = i % 2 == 0;
      alarm_collision = i % 2 == 1;
      step();
    end
    alarm_hang = 1'b0; alarm_collision = 1'b0;
    step();
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && !(rd_valid && rd_last); i++) step();
    step();
    rd_ready = 1'b0;
    set_data();
    alarm_hang = 1'b1;
    checks++;
    if (rd_valid !== 1'b0 || log_count !== 4'd8) begin errs++; $display("FAIL fp_load: got valid=%b count=%0d want 0/8", rd_valid, log_count); end
    step();
    checks++;
    if (log_count !== 4'd8 || log_full !== 1'b1 || drop_count !== 8'd0 || rd_valid !== 1'b1) begin
      errs++; $display("FAIL fp_accept: got count=%0d full=%b drop=%0d valid=%b want 8/1/0/1", log_count, log_full, drop_count, rd_valid);
    end
    alarm_hang = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 400 && got_q.size() < 10 * WPR; i++) step();
    checks++;
    if (got_q.size() != 10 * WPR || got_q[9*WPR][23:16] !== 8'd9) begin errs++; $display("FAIL fp_words: got %0d words want %0d with last seq 9", got_q.size(), 10 * WPR); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL fp_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask
  task automatic test_backpressure();
    logic stall, pl;
    logic [31:0] pd;
    flush();
    set_data();
    alarm_hang = 1'b1;
    step();
    alarm_hang = 1'b0;
    set_data();
    alarm_collision = 1'b1;
    step();
    alarm_collision = 1'b0;
    for (int i = 0; i < 300 && got_q.size() < 2 * WPR; i++) begin
      rd_ready = 1'($urandom_range(0, 1));
      stall = rd_valid && !rd_ready;
      pd = rd_data;
      pl = rd_last;
      step();
      if (stall) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== pd || rd_last !== pl) begin errs++; $display("FAIL bp_stable: got valid=%b data=%h last=%b want 1/%h/%b", rd_valid, rd_data, rd_last, pd, pl); end
      end
    end
    checks++;
    if (got_q.size() != 2 * WPR) begin errs++; $display("FAIL bp_words: got %0d want %0d", got_q.size(), 2 * WPR); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask
  task automatic test_abort(input bit use_rst);
    flush();
    for (int i = 0; i < 4; i++) begin
      set_data();
      alarm_hang = i % 2 == 0;
      alarm_collision = i % 2 == 1;
      step();
    end
    alarm_hang = 1'b0; alarm_collision = 1'b0;
    repeat (3) step();
    rd_ready = 1'b1;
    for (int i = 0; i < 20 && got_q.size() < 5; i++) step();
    rd_ready = 1'b0;
    if (use_rst) begin
      rst = 1'b1;
      #1;
    end else begin
      clr = 1'b1;
      step();
      clr = 1'b0;
    end
    checks++;
    if (rd_valid !== 1'b0 || log_count !== 4'd0 || drop_count !== 8'd0) begin
      errs++; $display("FAIL abort_%s: got valid=%b count=%0d drop=%0d want 0/0/0", use_rst ? "rst" : "clr", rd_valid, log_count, drop_count);
    end
    if (use_rst) begin
      step();
      rst = 1'b0;
      step();
    end
    got_q.delete(); exp_q.delete();
    rd_ready = 1'b1;
    set_data();
    alarm_hang = 1'b1;
    for (int i = 0; i < 40 && got_q.size() < WPR; i++) step();
    alarm_hang = 1'b0;
    checks++;
    if (got_q.size() != WPR || got_q[0][23:16] !== 8'd0) begin errs++; $display("FAIL abort_seq_%s: got %0d words seq %h want %0d words seq 0", use_rst ? "rst" : "clr", got_q.size(), got_q.size() ? got_q[0][23:16] : 8'hxx, WPR); end
    for (int i = 0; i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL abort_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    step();
  endtask
  initial begin
    test_reset();
    test_single_hang();
    test_simultaneous();
    test_overflow();
    test_full_pop();
    test_backpressure();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
